// File: rtl/result_collector_pkg.sv
// Shared types and constants for the result collector and its packet FIFO.
package result_collector_pkg;

    localparam int RESULT_W = 5;
    localparam int VALUE_W  = 11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_TAIL    = 2'd2,
        ST_DRAIN   = 2'd3
    } state_e;

    typedef logic [1:0] err_code_t;

    localparam err_code_t ERR_NONE  = 2'b00;
    localparam err_code_t ERR_SHORT = 2'b01;
    localparam err_code_t ERR_LONG  = 2'b10;
    localparam err_code_t ERR_OVF   = 2'b11;

endpackage

// File: rtl/pkt_fifo.sv
// Small synchronous FIFO holding assembled packets. A push is accepted
// when not full or when a pop happens in the same cycle (the pop frees the
// slot). The head word reads as zero while the FIFO is empty.
module pkt_fifo #(
    parameter int DEPTH = 2,   // power of two, >= 2
    parameter int WIDTH = 36
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] data_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_en;
    logic             rd_en;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_en   = pop_i && !empty_o;
    assign wr_en   = push_i && (!full_o || rd_en);
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    // Pointer advance for accepted writes and reads.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array write.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; empty pointers plus the zeroed head mux hide stale words.
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/result_collector.sv
// Collects BURST_LEN result beats from the upstream matcher into one packet,
// queues packets for a downstream consumer, flags short/long/overflow bursts
// and keeps running statistics (best value, accepted packet count).
module result_collector
    import result_collector_pkg::*;
#(
    parameter int BURST_LEN = 5,   // >= 2
    parameter int DEPTH     = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [RESULT_W-1:0]           result,
    input  logic [VALUE_W-1:0]            out_value,
    input  logic                          pkt_ready,
    output logic                          pkt_valid,
    output logic [BURST_LEN*RESULT_W-1:0] pkt_result,
    output logic [VALUE_W-1:0]            pkt_value,
    output logic                          err_pulse,
    output logic [1:0]                    err_code,
    output logic [VALUE_W-1:0]            best_value,
    output logic [7:0]                    pkt_count
);

    localparam int CNT_W   = $clog2(BURST_LEN);
    localparam int PKT_W   = BURST_LEN*RESULT_W + VALUE_W;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN-1);

    state_e                                 state_q, state_d;
    logic [CNT_W-1:0]                       cnt_q, cnt_d;
    // Beats 0..BURST_LEN-2; the last beat goes straight from the input into the packet.
    logic [BURST_LEN-2:0][RESULT_W-1:0]     beats_q, beats_d;
    logic                                   push_req;
    err_code_t                              fsm_err;
    err_code_t                              err_d;
    logic                                   err_pulse_q;
    err_code_t                              err_code_q;
    logic [VALUE_W-1:0]                     best_q, best_d;
    logic [7:0]                             count_q, count_d;

    logic                                   fifo_full;
    logic                                   fifo_empty;
    logic                                   pop;
    logic                                   push_ok;
    logic [PKT_W-1:0]                       fifo_din;
    logic [PKT_W-1:0]                       fifo_dout;

    assign pop      = !fifo_empty && pkt_ready;
    assign push_ok  = push_req && (!fifo_full || pop);
    assign fifo_din = {out_value, result, beats_q};

    pkt_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PKT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_req),
        .pop_i   (pop),
        .data_i  (fifo_din),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .data_o  (fifo_dout)
    );

    assign pkt_valid               = !fifo_empty;
    assign {pkt_value, pkt_result} = fifo_dout;
    assign err_pulse               = err_pulse_q;
    assign err_code                = err_code_q;
    assign best_value              = best_q;
    assign pkt_count               = count_q;

    // Burst framing FSM: next state, beat capture, push request and framing errors.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        beats_d  = beats_q;
        push_req = 1'b0;
        fsm_err  = ERR_NONE;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    beats_d[0] = result;
                    cnt_d      = CNT_W'(1);
                    state_d    = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (in_valid) begin
                    if (cnt_q == LAST_BEAT) begin
                        push_req = 1'b1;
                        cnt_d    = '0;
                        state_d  = ST_TAIL;
                    end else begin
                        for (int k = 0; k < BURST_LEN-1; k++) begin
                            if (cnt_q == CNT_W'(k)) beats_d[k] = result;
                        end
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    fsm_err = ERR_SHORT;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_TAIL: begin
                if (in_valid) begin
                    fsm_err = ERR_LONG;
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (!in_valid) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Error selection (framing errors win over overflow) and statistics update.
    always_comb begin
        err_d   = fsm_err;
        best_d  = best_q;
        count_d = count_q;
        if (fsm_err == ERR_NONE && push_req && !push_ok) err_d = ERR_OVF;
        if (push_ok) begin
            if (out_value > best_q) best_d = out_value;
            if (count_q != 8'hFF)   count_d = count_q + 8'd1;
        end
    end

    // FSM state and beat counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Beat holding registers; contents are only consumed after a full burst overwrites them.
    always_ff @(posedge clk) begin
        beats_q <= beats_d;
    end

    // Registered error strobe and statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_pulse_q <= 1'b0;
            err_code_q  <= ERR_NONE;
            best_q      <= '0;
            count_q     <= '0;
        end else begin
            err_pulse_q <= (err_d != ERR_NONE);
            err_code_q  <= err_d;
            best_q      <= best_d;
            count_q     <= count_d;
        end
    end

endmodule
